// File: rtl/alu.sv
// Accumulator-based ALU for the SRP16 datapath: a 16-bit accumulator plus a
// 1-bit carry/borrow/compare flag, with a tri-state accumulator bus output.
module alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    input  logic             read,
    input  logic             write,
    input  logic             writeu,
    output logic [WIDTH-1:0] accout,
    output logic             flag
);

    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_ADD    = 5'b00001;
    localparam logic [4:0] OP_SUB    = 5'b00010;
    localparam logic [4:0] OP_AND    = 5'b00011;
    localparam logic [4:0] OP_SHL    = 5'b00100;
    localparam logic [4:0] OP_SHR    = 5'b00101;
    localparam logic [4:0] OP_ASR    = 5'b00110;
    localparam logic [4:0] OP_OR     = 5'b00111;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_NOT    = 5'b01001;
    localparam logic [4:0] OP_ADC    = 5'b01010;
    localparam logic [4:0] OP_SBB    = 5'b01011;
    localparam logic [4:0] OP_CMPEQ  = 5'b01100;
    localparam logic [4:0] OP_CMPLTU = 5'b01101;
    localparam logic [4:0] OP_CMPLTS = 5'b01110;
    localparam logic [4:0] OP_ROL    = 5'b01111;
    localparam logic [4:0] OP_ROR    = 5'b10000;
    localparam logic [4:0] OP_INC    = 5'b10001;
    localparam logic [4:0] OP_DEC    = 5'b10010;

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               flag_q, flag_d;
    logic [3:0]         shamt;
    logic [WIDTH:0]     carryIn, addRes, subRes, shlRes, shrRes, asrRes;
    logic [2*WIDTH-1:0] rolRes, rorRes;

    assign shamt   = operand[3:0];
    assign carryIn = {{WIDTH{1'b0}}, flag_q};

    // Shifts run one bit wider than the accumulator so the bit that falls off
    // the end lands in the spare position and becomes the flag directly.
    always_comb begin
        addRes = {1'b0, acc_q} + {1'b0, operand};
        subRes = {1'b0, acc_q} - {1'b0, operand};
        shlRes = {1'b0, acc_q} << shamt;
        shrRes = {acc_q, 1'b0} >> shamt;
        asrRes = $unsigned($signed({acc_q, 1'b0}) >>> shamt);
        rolRes = {acc_q, acc_q} << shamt;
        rorRes = {acc_q, acc_q} >> shamt;
    end

    always_comb begin
        acc_d  = acc_q;
        flag_d = flag_q;
        if (write) begin
            acc_d = operand;
        end else if (writeu) begin
            acc_d = {operand[7:0], acc_q[7:0]};
        end else begin
            case (opcode)
                OP_ADD:    {flag_d, acc_d} = addRes;
                OP_SUB:    {flag_d, acc_d} = subRes;
                OP_AND: begin
                    acc_d  = acc_q & operand;
                    flag_d = (acc_d == '0);
                end
                OP_SHL:    {flag_d, acc_d} = shlRes;
                OP_SHR:    {acc_d, flag_d} = shrRes;
                OP_ASR:    {acc_d, flag_d} = asrRes;
                OP_OR: begin
                    acc_d  = acc_q | operand;
                    flag_d = (acc_d == '0);
                end
                OP_XOR: begin
                    acc_d  = acc_q ^ operand;
                    flag_d = (acc_d == '0);
                end
                OP_NOT: begin
                    acc_d  = ~acc_q;
                    flag_d = (acc_d == '0);
                end
                OP_ADC:    {flag_d, acc_d} = addRes + carryIn;
                OP_SBB:    {flag_d, acc_d} = subRes - carryIn;
                OP_CMPEQ:  flag_d = (acc_q == operand);
                OP_CMPLTU: flag_d = (acc_q < operand);
                OP_CMPLTS: flag_d = ($signed(acc_q) < $signed(operand));
                OP_ROL:    acc_d = rolRes[2*WIDTH-1:WIDTH];
                OP_ROR:    acc_d = rorRes[WIDTH-1:0];
                OP_INC:    {flag_d, acc_d} = {1'b0, acc_q} + {{WIDTH{1'b0}}, 1'b1};
                OP_DEC: begin
                    acc_d  = acc_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    flag_d = (acc_q == '0);
                end
                default: begin
                    acc_d  = acc_q;
                    flag_d = flag_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end

    assign accout = read ? acc_q : {WIDTH{1'bz}};
    assign flag   = flag_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed scenarios followed by random traffic,
// all compared against an integer-arithmetic model of the accumulator and flag.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [4:0]  opcode;
    logic [15:0] operand;
    logic        read;
    logic        write;
    logic        writeu;
    logic [15:0] accout;
    logic        flag;

    int vectors     = 0;
    int miscompares = 0;
    int mAcc        = 0;
    int mFlag       = 0;

    alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .operand(operand),
        .read   (read),
        .write  (write),
        .writeu (writeu),
        .accout (accout),
        .flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int toSigned(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference behaviour expressed as plain integer arithmetic on 0..65535.
    function automatic void modelStep(input bit w, input bit wu, input int op, input int opd);
        int n;
        int r;
        n = opd & 15;
        if (w) begin
            mAcc = opd;
        end else if (wu) begin
            mAcc = ((opd & 255) * 256) + (mAcc & 255);
        end else begin
            case (op)
                1: begin
                    r = mAcc + opd;
                    mFlag = (r > 65535) ? 1 : 0;
                    mAcc = r & 65535;
                end
                2: begin
                    mFlag = (mAcc < opd) ? 1 : 0;
                    mAcc = (mAcc - opd) & 65535;
                end
                3: begin mAcc = mAcc & opd; mFlag = (mAcc == 0) ? 1 : 0; end
                4: begin
                    mFlag = (n == 0) ? 0 : (mAcc >> (16 - n)) & 1;
                    mAcc = (mAcc << n) & 65535;
                end
                5: begin
                    mFlag = (n == 0) ? 0 : (mAcc >> (n - 1)) & 1;
                    mAcc = mAcc >> n;
                end
                6: begin
                    mFlag = (n == 0) ? 0 : (mAcc >> (n - 1)) & 1;
                    mAcc = (toSigned(mAcc) >>> n) & 65535;
                end
                7: begin mAcc = mAcc | opd; mFlag = (mAcc == 0) ? 1 : 0; end
                8: begin mAcc = mAcc ^ opd; mFlag = (mAcc == 0) ? 1 : 0; end
                9: begin mAcc = 65535 - mAcc; mFlag = (mAcc == 0) ? 1 : 0; end
                10: begin
                    r = mAcc + opd + mFlag;
                    mFlag = (r > 65535) ? 1 : 0;
                    mAcc = r & 65535;
                end
                11: begin
                    r = mAcc - opd - mFlag;
                    mFlag = (r < 0) ? 1 : 0;
                    mAcc = r & 65535;
                end
                12: mFlag = (mAcc == opd) ? 1 : 0;
                13: mFlag = (mAcc < opd) ? 1 : 0;
                14: mFlag = (toSigned(mAcc) < toSigned(opd)) ? 1 : 0;
                15: mAcc = ((mAcc << n) | (mAcc >> (16 - n))) & 65535;
                16: mAcc = ((mAcc >> n) | (mAcc << (16 - n))) & 65535;
                17: begin
                    r = mAcc + 1;
                    mFlag = (r > 65535) ? 1 : 0;
                    mAcc = r & 65535;
                end
                18: begin
                    mFlag = (mAcc == 0) ? 1 : 0;
                    mAcc = (mAcc - 1) & 65535;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic checkOutput(input string tag);
        logic [15:0] expAcc;
        logic        expFlag;
        expAcc  = mAcc[15:0];
        expFlag = mFlag[0];
        vectors++;
        assert (accout === expAcc) else begin
            miscompares++;
            $error("FAIL %s.acc observed %h expected %h", tag, accout, expAcc);
        end
        vectors++;
        assert (flag === expFlag) else begin
            miscompares++;
            $error("FAIL %s.flag observed %b expected %b", tag, flag, expFlag);
        end
    endtask

    task automatic checkConst(input string tag, input logic [15:0] expAcc, input logic expFlag);
        vectors++;
        assert (accout === expAcc && flag === expFlag) else begin
            miscompares++;
            $error("FAIL %s observed %h/%b expected %h/%b", tag, accout, flag, expAcc, expFlag);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic wu, input logic [4:0] op,
                                 input logic [15:0] opd, input string tag);
        write   = w;
        writeu  = wu;
        opcode  = op;
        operand = opd;
        read    = 1'b1;
        @(posedge clk);
        modelStep(w, wu, int'(op), int'(opd));
        #1;
        write  = 1'b0;
        writeu = 1'b0;
        opcode = 5'b00000;
        checkOutput(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        read    = 1'b1;
        write   = 1'b0;
        writeu  = 1'b0;
        opcode  = 5'b00000;
        operand = 16'h0000;
        #2;
        checkOutput("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 5'b00000, 16'h0000, "load0");
        applyStimulus(1'b1, 1'b0, 5'b00000, 16'h0008, "load8");
        applyStimulus(1'b0, 1'b0, 5'b00100, 16'h0002, "shl2");
        checkConst("shl2_const", 16'h0020, 1'b0);

        applyStimulus(1'b1, 1'b0, 5'b00000, 16'h00AB, "loadAB");
        applyStimulus(1'b0, 1'b1, 5'b00000, 16'h00CD, "upperCD");
        checkConst("upper_const", 16'hCDAB, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'b00001, 16'h1234, "writeWins");
        checkConst("writeWins_const", 16'h1234, 1'b0);

        applyStimulus(1'b1, 1'b0, 5'b00000, 16'hFFFF, "loadFFFF");
        applyStimulus(1'b0, 1'b0, 5'b00001, 16'h0001, "add1");
        checkConst("add1_const", 16'h0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'b01010, 16'h0000, "adc0");
        checkConst("adc0_const", 16'h0001, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'b00010, 16'h0002, "sub2");
        checkConst("sub2_const", 16'hFFFF, 1'b1);

        applyStimulus(1'b1, 1'b0, 5'b00000, 16'h8000, "load8000");
        applyStimulus(1'b0, 1'b0, 5'b01110, 16'h0001, "cmplts");
        checkConst("cmplts_const", 16'h8000, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'b01101, 16'h0001, "cmpltu");
        checkConst("cmpltu_const", 16'h8000, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'b00110, 16'h0004, "asr4");
        checkConst("asr4_const", 16'hF800, 1'b0);

        applyStimulus(1'b0, 1'b0, 5'b11111, 16'hFFFF, "unused11111");
        checkConst("unused_const", 16'hF800, 1'b0);
        read = 1'b0;
        #1;
        vectors++;
        assert (accout === 16'hzzzz) else begin
            miscompares++;
            $error("FAIL busZ observed %h expected zzzz", accout);
        end
        read = 1'b1;

        applyStimulus(1'b0, 1'b0, 5'b00100, 16'h0000, "shl0");
        applyStimulus(1'b0, 1'b0, 5'b00101, 16'h0000, "shr0");
        applyStimulus(1'b0, 1'b0, 5'b00100, 16'h000F, "shl15");
        applyStimulus(1'b1, 1'b0, 5'b00000, 16'h0000, "load0b");
        applyStimulus(1'b0, 1'b0, 5'b10010, 16'h0000, "decZero");
        applyStimulus(1'b0, 1'b0, 5'b10001, 16'h0000, "incWrap");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                          5'($urandom_range(0, 31)), 16'($urandom), "random");
        end

        applyStimulus(1'b1, 1'b0, 5'b00000, 16'hBEEF, "preReset");
        applyStimulus(1'b0, 1'b0, 5'b10001, 16'h0000, "preResetInc");
        // Asynchronous reset asserted between edges must clear state at once.
        rst_n = 1'b0;
        mAcc  = 0;
        mFlag = 0;
        #1;
        checkOutput("reset_mid");
        checkConst("reset_mid_const", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'b10010, 16'h0000, "postResetDec");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
